// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 fetch queue.
package fetch_pkg;

  localparam int PC_STEP      = 4;
  localparam int FQ_DEPTH_DEF = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: instruction-memory port, branch redirect and decode handshake.
interface fetch_queue_if #(
  parameter int N = 64
);

  logic [N-1:0] IM_addr;
  logic [31:0]  IM_readData;
  logic         redirect;
  logic [N-1:0] PCBranch;
  logic [31:0]  instr_out;
  logic [N-1:0] pc_out;
  logic         valid_out;
  logic         ready_in;

  modport master (
    output IM_addr,
    input  IM_readData,
    input  redirect,
    input  PCBranch,
    output instr_out,
    output pc_out,
    output valid_out,
    input  ready_in
  );

  modport slave (
    input  IM_addr,
    output IM_readData,
    output redirect,
    output PCBranch,
    input  instr_out,
    input  pc_out,
    input  valid_out,
    output ready_in
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular queue of {pc, instr}; head output gated to zero while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic         valid,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush && push) mem[tail] <= wr_entry;
  end

  assign valid    = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_entry = valid ? mem[head] : '0;

endmodule

// File: rtl/fetch_queue.sv
// LEGv8 fetch stage: PC register, imem addressing, redirect/push/pop arbitration.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = FQ_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_queue_if.master        fq,
  output logic [31:0]          fetch_cnt,
  output logic [31:0]          flush_cnt
);

  logic [N-1:0] pc_p0;
  logic         push;
  logic         pop;
  logic         full;
  logic         vld_p1;
  fetch_entry_t wr_entry_p0;
  fetch_entry_t rd_entry_p1;

  assign pop  = vld_p1 & fq.ready_in & ~fq.redirect;
  assign push = ~fq.redirect & (~full | pop);

  always_ff @(posedge clk) begin
    if (!reset)           pc_p0 <= '0;
    else if (fq.redirect) pc_p0 <= fq.PCBranch;
    else if (push)        pc_p0 <= pc_p0 + N'(PC_STEP);
  end

  assign fq.IM_addr        = pc_p0;
  assign wr_entry_p0.pc    = 64'(pc_p0);
  assign wr_entry_p0.instr = fq.IM_readData;

  // Queue boundary: everything downstream is registered state.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (fq.redirect),
    .wr_entry (wr_entry_p0),
    .rd_entry (rd_entry_p1),
    .valid    (vld_p1),
    .full     (full)
  );

  assign fq.instr_out = rd_entry_p1.instr;
  assign fq.pc_out    = rd_entry_p1.pc[N-1:0];
  assign fq.valid_out = vld_p1;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push && fetch_cnt_q != '1)        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (fq.redirect && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; imem model returns word k at byte address 4k.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
  int          vectors;
  int          miscompares;

  fetch_queue_if #(.N(64)) bus ();

  assign bus.IM_readData = bus.IM_addr[33:2];

  fetch_queue #(
    .N     (64),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fq        (bus),
    .fetch_cnt (fetch_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset        = 1'b0;
    bus.redirect = 1'b0;
    bus.PCBranch = '0;
    bus.ready_in = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (bus.valid_out !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out);
    end
    vectors++;
    if (bus.IM_addr !== 64'd0) begin
      miscompares++; $display("FAIL reset_im_addr: got %h expected 0", bus.IM_addr);
    end
    vectors++;
    if (bus.pc_out !== 64'd0) begin
      miscompares++; $display("FAIL reset_pc_out: got %h expected 0", bus.pc_out);
    end
    vectors++;
    if (bus.instr_out !== 32'd0) begin
      miscompares++; $display("FAIL reset_instr_out: got %h expected 0", bus.instr_out);
    end
  endtask

  task automatic test_stream();
    reset        = 1'b1;
    bus.ready_in = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step();
      vectors++;
      if (bus.valid_out !== 1'b1) begin
        miscompares++; $display("FAIL stream_valid[%0d]: got %b expected 1", j, bus.valid_out);
      end
      vectors++;
      if (bus.pc_out !== 64'(4 * (j - 1))) begin
        miscompares++; $display("FAIL stream_pc_out[%0d]: got %h expected %h", j, bus.pc_out, 64'(4 * (j - 1)));
      end
      vectors++;
      if (bus.instr_out !== 32'(j - 1)) begin
        miscompares++; $display("FAIL stream_instr[%0d]: got %h expected %h", j, bus.instr_out, 32'(j - 1));
      end
    end
  endtask

  task automatic test_stall_fill();
    logic [63:0] exp_addr;
    apply_reset();
    reset = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      step();
      exp_addr = (j < 4) ? 64'(4 * j) : 64'h10;
      vectors++;
      if (bus.IM_addr !== exp_addr) begin
        miscompares++; $display("FAIL stall_im_addr[%0d]: got %h expected %h", j, bus.IM_addr, exp_addr);
      end
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.pc_out !== 64'd0) begin
        miscompares++; $display("FAIL stall_head[%0d]: got valid=%b pc=%h expected valid=1 pc=0", j, bus.valid_out, bus.pc_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.ready_in = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      vectors++;
      if (bus.pc_out !== 64'(4 * j)) begin
        miscompares++; $display("FAIL full_pc_out[%0d]: got %h expected %h", j, bus.pc_out, 64'(4 * j));
      end
      vectors++;
      if (bus.IM_addr !== 64'(16 + 4 * j)) begin
        miscompares++; $display("FAIL full_im_addr[%0d]: got %h expected %h", j, bus.IM_addr, 64'(16 + 4 * j));
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    reset = 1'b1;
    step(); step(); step();
    bus.redirect = 1'b1;
    bus.PCBranch = 64'h40;
    bus.ready_in = 1'b1;
    step();
    vectors++;
    if (bus.valid_out !== 1'b0) begin
      miscompares++; $display("FAIL redir_valid: got %b expected 0", bus.valid_out);
    end
    vectors++;
    if (bus.IM_addr !== 64'h40) begin
      miscompares++; $display("FAIL redir_im_addr: got %h expected 40", bus.IM_addr);
    end
    bus.redirect = 1'b0;
    step();
    vectors++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== 64'h40 || bus.instr_out !== 32'h10) begin
      miscompares++; $display("FAIL redir_first: got valid=%b pc=%h instr=%h expected 1/40/10", bus.valid_out, bus.pc_out, bus.instr_out);
    end
    step();
    vectors++;
    if (bus.pc_out !== 64'h44) begin
      miscompares++; $display("FAIL redir_second: got %h expected 44", bus.pc_out);
    end
  endtask

  task automatic test_pc_wrap();
    bus.redirect = 1'b1;
    bus.PCBranch = 64'hFFFF_FFFF_FFFF_FFFC;
    bus.ready_in = 1'b1;
    step();
    vectors++;
    if (bus.IM_addr !== 64'hFFFF_FFFF_FFFF_FFFC || bus.valid_out !== 1'b0) begin
      miscompares++; $display("FAIL wrap_target: got addr=%h valid=%b expected fffffffffffffffc/0", bus.IM_addr, bus.valid_out);
    end
    bus.redirect = 1'b0;
    bus.ready_in = 1'b0;
    step();
    vectors++;
    if (bus.IM_addr !== 64'd0) begin
      miscompares++; $display("FAIL wrap_im_addr: got %h expected 0", bus.IM_addr);
    end
    vectors++;
    if (bus.pc_out !== 64'hFFFF_FFFF_FFFF_FFFC || bus.instr_out !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL wrap_entry: got pc=%h instr=%h expected fffffffffffffffc/ffffffff", bus.pc_out, bus.instr_out);
    end
    step();
    vectors++;
    if (bus.IM_addr !== 64'd4 || bus.pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      miscompares++; $display("FAIL wrap_hold: got addr=%h pc=%h expected 4/fffffffffffffffc", bus.IM_addr, bus.pc_out);
    end
  endtask

  task automatic test_reset_override();
    bus.ready_in = 1'b1;
    step(); step();
    reset        = 1'b0;
    bus.redirect = 1'b1;
    bus.PCBranch = 64'h80;
    step();
    vectors++;
    if (bus.valid_out !== 1'b0 || bus.IM_addr !== 64'd0 || bus.pc_out !== 64'd0) begin
      miscompares++; $display("FAIL ovr_state: got valid=%b addr=%h pc=%h expected 0/0/0", bus.valid_out, bus.IM_addr, bus.pc_out);
    end
    vectors++;
    if (flush_cnt !== 32'd0 || fetch_cnt !== 32'd0) begin
      miscompares++; $display("FAIL ovr_counters: got fetch=%0d flush=%0d expected 0/0", fetch_cnt, flush_cnt);
    end
    reset        = 1'b1;
    bus.redirect = 1'b0;
    step();
    vectors++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== 64'd0 || bus.IM_addr !== 64'd4) begin
      miscompares++; $display("FAIL ovr_restart: got valid=%b pc=%h addr=%h expected 1/0/4", bus.valid_out, bus.pc_out, bus.IM_addr);
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_fetch;
    logic [31:0] exp_flush;
    apply_reset();
    reset        = 1'b1;
    bus.ready_in = 1'b1;
    step(); step(); step();
    bus.redirect = 1'b1;
    bus.PCBranch = 64'h100;
    step();
    bus.redirect = 1'b0;
    step(); step();
`ifdef FETCH_PERF_EN
    exp_fetch = 32'd5;
    exp_flush = 32'd1;
`else
    exp_fetch = 32'd0;
    exp_flush = 32'd0;
`endif
    vectors++;
    if (fetch_cnt !== exp_fetch) begin
      miscompares++; $display("FAIL perf_fetch: got %0d expected %0d", fetch_cnt, exp_fetch);
    end
    vectors++;
    if (flush_cnt !== exp_flush) begin
      miscompares++; $display("FAIL perf_flush: got %0d expected %0d", flush_cnt, exp_flush);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    bus.redirect = 1'b0;
    bus.PCBranch = '0;
    bus.ready_in = 1'b0;
    test_reset();
    test_stream();
    test_stall_fill();
    test_back_to_back();
    test_redirect();
    test_pc_wrap();
    test_reset_override();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
